// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TDO collection path.
package jtag_pkg;

  localparam int JTAG_VEC_W  = 32;
  localparam int DROP_CNT_W  = 16;

  typedef struct packed {
    logic                  last;
    logic [JTAG_VEC_W-1:0] vec;
  } tdo_entry_t;

  localparam int TDO_ENTRY_W = $bits(tdo_entry_t);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/jtag_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head entry.
// Occupancy counts the head, so DEPTH entries are usable in total.
module jtag_sync_fifo
  import jtag_pkg::*;
#(
  parameter int WIDTH = TDO_ENTRY_W,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             empty_s, do_pop_s, do_push_s;

  assign empty_s   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_s;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
    level_d = wr_d - rd_d;
    valid_d = (wr_d != rd_d);
  end

  // The new head bypasses the array when it is the slot being written this cycle.
  always_comb begin
    dout_d = dout_q;
    if (do_push_s && (wr_q == rd_d)) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign level_o = level_q;

endmodule

// File: rtl/jtag_tdo_collect.sv
// Buffers TDO vectors from the shift engine and streams them out as AXI-Stream
// packets; overflow drops are counted because the engine cannot stall.
module jtag_tdo_collect
  import jtag_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH        = 8,
  parameter int C_WORDS_PER_PACKET  = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           DONE,
  input  logic [JTAG_VEC_W-1:0]          TDO_VECTOR,
  input  logic                           LAST,
  input  logic                           CLR_OVERFLOW,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           OVERFLOW,
  output logic [DROP_CNT_W-1:0]          DROP_COUNT,
  output logic [$clog2(C_FIFO_DEPTH):0]  FIFO_LEVEL
);

  localparam logic [15:0] LAST_BEAT = 16'(C_WORDS_PER_PACKET - 1);

  tdo_entry_t                push_entry_s, head_s;
  logic                      fifo_full_s, fifo_valid_s;
  logic                      pop_s, push_s, drop_s, tlast_s;
  logic [15:0]               beat_cnt_q, beat_cnt_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  assign push_entry_s = '{last: LAST, vec: TDO_VECTOR};
  assign pop_s        = fifo_valid_s && m_axis_tready;
  assign push_s       = DONE && (!fifo_full_s || pop_s);
  assign drop_s       = DONE && !push_s;

  jtag_sync_fifo #(
    .WIDTH (TDO_ENTRY_W),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_s),
    .din_i   (push_entry_s),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .valid_o (fifo_valid_s),
    .full_o  (fifo_full_s),
    .level_o (FIFO_LEVEL)
  );

  // beat_cnt only moves on pops, which keeps tlast stable during a stall.
  assign tlast_s = fifo_valid_s && (head_s.last || (beat_cnt_q == LAST_BEAT));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop_s) begin
      if (tlast_s) begin
        beat_cnt_d = 16'd0;
      end else begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (CLR_OVERFLOW) begin
        drop_cnt_d = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
    end else if (CLR_OVERFLOW) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      beat_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_axis_tdata  = head_s.vec;
  assign m_axis_tvalid = fifo_valid_s;
  assign m_axis_tlast  = tlast_s;
  assign OVERFLOW      = overflow_q;
  assign DROP_COUNT    = drop_cnt_q;

endmodule

// File: tb/tb_jtag_tdo_collect.sv
// Directed and randomized bench for jtag_tdo_collect against a queue-based model.
module tb_jtag_tdo_collect;

  localparam int DEPTH = 8;
  localparam int WPP   = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DONE = 1'b0;
  logic [31:0] TDO_VECTOR = 32'd0;
  logic        LAST = 1'b0;
  logic        CLR_OVERFLOW = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        OVERFLOW;
  logic [15:0] DROP_COUNT;
  logic [3:0]  FIFO_LEVEL;

  jtag_tdo_collect #(
    .C_M_AXIS_DATA_WIDTH (32),
    .C_FIFO_DEPTH        (DEPTH),
    .C_WORDS_PER_PACKET  (WPP)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .DONE          (DONE),
    .TDO_VECTOR    (TDO_VECTOR),
    .LAST          (LAST),
    .CLR_OVERFLOW  (CLR_OVERFLOW),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .OVERFLOW      (OVERFLOW),
    .DROP_COUNT    (DROP_COUNT),
    .FIFO_LEVEL    (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference state: queued {last, vec} entries, beats since packet start, drop status.
  logic [32:0] mq[$];
  int          m_beats = 0;
  int          m_drops = 0;
  logic        m_ovf = 1'b0;
  logic [32:0] seen[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_tlast();
    return (mq.size() != 0) && (mq[0][32] || (m_beats == WPP - 1));
  endfunction

  task automatic check_outputs();
    chk("tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
    chk("level", 64'(FIFO_LEVEL), 64'(mq.size()));
    chk("overflow", 64'(OVERFLOW), 64'(m_ovf));
    chk("drop_count", 64'(DROP_COUNT), 64'(m_drops));
    if (mq.size() != 0) begin
      chk("tdata", 64'(m_axis_tdata), 64'(mq[0][31:0]));
      chk("tlast", 64'(m_axis_tlast), 64'(m_tlast()));
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic d, input logic [31:0] v, input logic l,
                     input logic rdy, input logic clr);
    logic pop_m, push_m, tl_m;
    DONE = d; TDO_VECTOR = v; LAST = l; m_axis_tready = rdy; CLR_OVERFLOW = clr;
    if (m_axis_tvalid && rdy) seen.push_back({m_axis_tlast, m_axis_tdata});
    tl_m   = m_tlast();
    pop_m  = (mq.size() != 0) && rdy;
    push_m = d && ((mq.size() < DEPTH) || pop_m);
    @(posedge CLK);
    if (pop_m) begin
      m_beats = tl_m ? 0 : m_beats + 1;
      void'(mq.pop_front());
    end
    if (d && !push_m) begin
      m_ovf   = 1'b1;
      m_drops = clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
    end else if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    if (push_m) mq.push_back({l, v});
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic do_reset(input logic d);
    RESET = 1'b1; DONE = d; TDO_VECTOR = 32'h1234_5678; LAST = 1'b1;
    m_axis_tready = 1'b0; CLR_OVERFLOW = 1'b0;
    @(posedge CLK);
    mq.delete(); seen.delete();
    m_beats = 0; m_drops = 0; m_ovf = 1'b0;
    @(negedge CLK);
    RESET = 1'b0; DONE = 1'b0;
    check_outputs();
    chk("reset_tdata", 64'(m_axis_tdata), 64'h0);
    chk("reset_tlast", 64'(m_axis_tlast), 64'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && mq.size() != 0; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("drained", 64'(m_axis_tvalid), 64'h0);
  endtask

  initial begin
    int ntl;
    @(negedge CLK);
    do_reset(1'b1);

    // Basic single vector with LAST.
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    chk("basic_tdata", 64'(m_axis_tdata), 64'hDEAD_BEEF);
    chk("basic_tlast", 64'(m_axis_tlast), 64'h1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("basic_level", 64'(FIFO_LEVEL), 64'h0);
    chk("basic_beat", 64'(seen.size() == 1 ? seen[0] : 33'h0), 64'h1_DEAD_BEEF);

    // Backpressure: fill, overflow, then full push+pop.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
    chk("bp_overflow", 64'(OVERFLOW), 64'h1);
    chk("bp_drops", 64'(DROP_COUNT), 64'h1);
    chk("bp_level", 64'(FIFO_LEVEL), 64'h8);
    chk("bp_stall_hold", 64'(m_axis_tdata), 64'h1);
    cyc(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_level", 64'(FIFO_LEVEL), 64'h8);
    chk("full_pushpop_drops", 64'(DROP_COUNT), 64'h1);
    drain();
    chk("bp_beats", 64'(seen.size()), 64'd9);
    for (int i = 0; i < 9 && i < seen.size(); i++)
      chk("bp_order", 64'(seen[i][31:0]), (i < 8) ? 64'(i + 1) : 64'hA);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("clr_overflow", 64'({OVERFLOW, DROP_COUNT}), 64'h0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i + 32'h100), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", 64'({OVERFLOW, DROP_COUNT}), 64'h1_0001);
    drain();

    // Forced tlast every 16 beats.
    do_reset(1'b0);
    for (int i = 1; i <= 40; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
    drain();
    chk("forced_count", 64'(seen.size()), 64'd40);
    if (seen.size() == 40) begin
      chk("forced_b16", 64'(seen[15][32]), 64'h1);
      chk("forced_b32", 64'(seen[31][32]), 64'h1);
      chk("forced_b40", 64'(seen[39][32]), 64'h0);
    end
    ntl = 0;
    foreach (seen[i]) ntl += int'(seen[i][32]);
    chk("forced_ntlast", 64'(ntl), 64'd2);

    // Early LAST restarts the packet count.
    do_reset(1'b0);
    for (int i = 1; i <= 21; i++) cyc(1'b1, 32'(i), 1'b1 ? (i == 5) : 1'b0, 1'b1, 1'b0);
    drain();
    chk("early_count", 64'(seen.size()), 64'd21);
    if (seen.size() == 21) begin
      chk("early_b5", 64'(seen[4][32]), 64'h1);
      chk("early_b21", 64'(seen[20][32]), 64'h1);
    end
    ntl = 0;
    foreach (seen[i]) ntl += int'(seen[i][32]);
    chk("early_ntlast", 64'(ntl), 64'd2);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i + 32'h50), 1'b0, 1'b0, 1'b0);
    do_reset(1'b0);
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("midrst_level", 64'(FIFO_LEVEL), 64'h0);
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0);
    chk("midrst_new", 64'(m_axis_tdata), 64'hA5A5_A5A5);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(99, 0) < 70), $urandom, ($urandom_range(7, 0) == 0),
          ($urandom_range(99, 0) < 55), ($urandom_range(63, 0) == 0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
